// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding imem read at a time, a
// single-entry hold buffer for responses that land during a stall, and a
// kill state that swallows the response to a request made obsolete by a
// redirect from execute.
module fetch_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_LAT_MIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] PCF
);

    // A zero-cycle memory would need the ack in the same cycle as the request,
    // which the REQ/WAIT split cannot accept.
    if (IMEM_LAT_MIN < 1) begin : g_bad_lat
        $error("fetch_controller: IMEM_LAT_MIN must be at least 1");
    end

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        KILL
    } state_t;

    // Response parked while decode is stalled.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } hold_t;

    state_t      state;
    hold_t       hold;
    logic [31:0] pc_target;
    logic [31:0] pcf_plus4;
    logic [31:0] hold_plus4;

    // Redirect targets are word aligned; low bits from execute are dropped.
    assign pc_target  = {PCTargetE[31:2], 2'b00};
    assign pcf_plus4  = PCF + 32'd4;
    assign hold_plus4 = hold.pc + 32'd4;

    // The request address is simply the fetch PC; it only matters while
    // imem_req is high, i.e. while the FSM sits in REQ.
    assign imem_addr = PCF;

    // Fetch FSM. imem_req is registered and raised on every transition
    // into REQ, so it is high for exactly the cycle spent in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            PCF      <= RESET_PC;
            imem_req <= 1'b0;
            InstrD   <= 32'd0;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
            hold     <= '0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                // One idle cycle out of reset; redirects are ignored here.
                BOOT: begin
                    if (!StallF) ValidD <= 1'b0;
                    state    <= REQ;
                    imem_req <= 1'b1;
                end

                // The request goes out at the current PCF even if a redirect
                // arrives now; its response is then discarded in KILL.
                REQ: begin
                    if (PCSrcE) begin
                        PCF    <= pc_target;
                        ValidD <= 1'b0;
                        state  <= KILL;
                    end else begin
                        if (!StallF) ValidD <= 1'b0;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (PCSrcE) begin
                        PCF    <= pc_target;
                        ValidD <= 1'b0;
                        if (imem_ack) begin
                            // Response and redirect together: drop the data,
                            // nothing left outstanding, fetch the target now.
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= KILL;
                        end
                    end else if (imem_ack) begin
                        if (!StallF) begin
                            InstrD   <= imem_rdata;
                            PCD      <= PCF;
                            PCPlus4D <= pcf_plus4;
                            ValidD   <= 1'b1;
                            PCF      <= pcf_plus4;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            // Decode is frozen; park the word until it frees.
                            hold  <= '{instr: imem_rdata, pc: PCF};
                            state <= HOLD;
                        end
                    end else if (!StallF) begin
                        ValidD <= 1'b0;
                    end
                end

                HOLD: begin
                    if (PCSrcE) begin
                        PCF      <= pc_target;
                        ValidD   <= 1'b0;
                        hold     <= '0;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (!StallF) begin
                        InstrD   <= hold.instr;
                        PCD      <= hold.pc;
                        PCPlus4D <= hold_plus4;
                        ValidD   <= 1'b1;
                        PCF      <= hold_plus4;
                        hold     <= '0;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                // Waiting out the stale response; a later redirect simply
                // replaces the target we will fetch next.
                KILL: begin
                    if (PCSrcE) begin
                        PCF    <= pc_target;
                        ValidD <= 1'b0;
                    end else if (!StallF) begin
                        ValidD <= 1'b0;
                    end
                    if (imem_ack) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a fixed vector table for straight-line fetch
// and stall/hold, directed sequences for redirect corners, reset-in-HOLD and
// the wrapped reset PC, then randomized traffic against a transaction-level
// model driven by a variable-latency memory responder.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst, StallF, PCSrcE, imem_ack;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req, ValidD;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D, PCF;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pcd, w_pc4, w_pcf;

    always #5 clk = ~clk;

    fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_LAT_MIN(1)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCF(PCF)
    );

    // Same stimulus and memory timing, reset PC at the top of the address space.
    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .IMEM_LAT_MIN(1)) dut_wrap (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pc4), .ValidD(w_valid), .PCF(w_pcf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_boot, m_issue, m_out, m_drop, m_held;
    logic [31:0] m_pc, m_hinstr, m_instr, m_pcd, m_pc4;
    bit          m_valid;

    function automatic void deliver(input logic [31:0] instr, input logic [31:0] pc);
        m_instr = instr;
        m_pcd   = pc;
        m_pc4   = pc + 32'd4;
        m_valid = 1'b1;
    endfunction

    function automatic void model_step(input logic ack, input logic [31:0] rd);
        logic [31:0] tgt;
        tgt = PCTargetE & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc = 32'd0; m_boot = 1; m_issue = 0; m_out = 0; m_drop = 0; m_held = 0;
            m_hinstr = 32'd0; m_instr = 32'd0; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 0;
        end else if (m_boot) begin
            m_boot = 0; m_issue = 1;
            if (!StallF) m_valid = 0;
        end else if (m_issue) begin
            m_issue = 0; m_out = 1; m_drop = PCSrcE;
            if (PCSrcE) begin m_pc = tgt; m_valid = 0; end
            else if (!StallF) m_valid = 0;
        end else if (m_out) begin
            if (PCSrcE) begin
                m_pc = tgt; m_valid = 0;
                if (ack) begin m_out = 0; m_drop = 0; m_issue = 1; end
                else m_drop = 1;
            end else if (ack) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0; m_issue = 1;
                    if (!StallF) m_valid = 0;
                end else if (!StallF) begin
                    deliver(rd, m_pc); m_pc = m_pc + 32'd4; m_issue = 1;
                end else begin
                    m_held = 1; m_hinstr = rd;
                end
            end else if (!StallF) begin
                m_valid = 0;
            end
        end else if (m_held) begin
            if (PCSrcE) begin
                m_held = 0; m_pc = tgt; m_valid = 0; m_issue = 1;
            end else if (!StallF) begin
                deliver(m_hinstr, m_pc); m_pc = m_pc + 32'd4; m_held = 0; m_issue = 1;
            end
        end
    endfunction

    // ---------------- memory responder ----------------
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = 32'd0;
    bit          lat_mode = 0;
    int          lat_fixed = 1;
    bit          spur = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // One clock: drive memory response, clock, advance model, compare.
    task automatic cycle();
        logic        req_now, ackv;
        logic [31:0] addr_now, rd;
        ackv = (pend && cnt == 1) || spur;
        rd   = (pend && cnt == 1) ? memword(paddr) : $urandom;
        imem_ack   = ackv;
        imem_rdata = rd;
        req_now  = imem_req;
        addr_now = imem_addr;
        @(posedge clk);
        model_step(ackv, rd);
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (cnt == 1) pend = 0;
                else cnt--;
            end
            if (req_now === 1'b1) begin
                chk("single_outstanding", 32'(pend), 32'd0);
                pend  = 1;
                paddr = addr_now;
                cnt   = lat_mode ? int'($urandom_range(1, 4)) : lat_fixed;
            end
        end
        #1;
        chk("imem_req", 32'(imem_req), 32'(m_issue));
        if (m_issue) chk("imem_addr", imem_addr, m_pc);
        chk("PCF", PCF, m_pc);
        chk("ValidD", 32'(ValidD), 32'(m_valid));
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pc4);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        rstv;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pcd;
        logic [31:0] exp_pcf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        // straight-line fetch at latency 1, then a 3-cycle stall across the ack for 0x10
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00, 32'h04};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h04};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 32'h08};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h04, 32'h08};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h0C};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h08, 32'h0C};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10, 32'h14};

        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;

        for (int i = 0; i < 14; i++) begin
            rst    = tbl[i].rstv;
            StallF = tbl[i].stall;
            cycle();
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(ValidD), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pcd", i), PCD, tbl[i].exp_pcd);
            chk($sformatf("tbl%0d_pcf", i), PCF, tbl[i].exp_pcf);
            if (i == 1) begin
                chk("wrap_first_req", 32'(w_req), 32'd1);
                chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
            end
            if (i == 3) begin
                chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
                chk("wrap_pc4", w_pc4, 32'h0000_0000);
                chk("wrap_valid", 32'(w_valid), 32'd1);
                chk("wrap_second_req", 32'(w_req), 32'd1);
                chk("wrap_second_addr", w_addr, 32'h0000_0000);
            end
        end
        StallF = 1'b0;

        // Acks in BOOT and REQ are protocol errors and must be ignored.
        rst = 1'b1; cycle(); rst = 1'b0;
        spur = 1'b1; cycle();
        chk("spur_boot_valid", 32'(ValidD), 32'd0);
        cycle(); spur = 1'b0;
        chk("spur_req_valid", 32'(ValidD), 32'd0);
        cycle();
        chk("after_spur_pcd", PCD, 32'h0);
        chk("after_spur_valid", 32'(ValidD), 32'd1);

        // Redirect in REQ, then redirect during WAIT at 0x40 with latency 4.
        lat_fixed = 4;
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle();
        PCSrcE = 1'b1; PCTargetE = 32'h40; cycle(); PCSrcE = 1'b0;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h40) && n < 20) begin cycle(); n++; end
        chk("req_0x40_seen", 32'(imem_req), 32'd1);
        cycle();
        PCSrcE = 1'b1; PCTargetE = 32'h203; cycle(); PCSrcE = 1'b0;
        chk("kill_pcf", PCF, 32'h200);
        chk("kill_no_req", 32'(imem_req), 32'd0);
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            chk("kill_valid_low", 32'(ValidD), 32'd0);
            cycle(); n++;
        end
        chk("post_kill_req", 32'(imem_req), 32'd1);
        chk("post_kill_addr", imem_addr, 32'h200);
        chk("post_kill_valid", 32'(ValidD), 32'd0);

        // Redirect coincident with the ack in WAIT (latency 2): no KILL.
        lat_fixed = 2;
        cycle();
        cycle();
        PCSrcE = 1'b1; PCTargetE = 32'h300; cycle(); PCSrcE = 1'b0;
        chk("ackflush_req", 32'(imem_req), 32'd1);
        chk("ackflush_addr", imem_addr, 32'h300);
        chk("ackflush_valid", 32'(ValidD), 32'd0);

        // Deliver 0x300, park 0x304 in HOLD, then reset.
        lat_fixed = 1;
        cycle(); cycle();
        chk("pre_hold_pcd", PCD, 32'h300);
        StallF = 1'b1;
        cycle(); cycle();
        chk("hold_no_req", 32'(imem_req), 32'd0);
        chk("hold_pcf", PCF, 32'h304);
        rst = 1'b1; cycle(); rst = 1'b0; StallF = 1'b0;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_valid", 32'(ValidD), 32'd0);
        cycle();
        chk("boot_then_req", 32'(imem_req), 32'd1);
        chk("boot_then_addr", imem_addr, 32'h0);

        // Randomized traffic with variable latency.
        lat_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            StallF    = ($urandom_range(0, 3) == 0);
            PCSrcE    = ($urandom_range(0, 9) == 0);
            PCTargetE = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            cycle();
        end
        rst = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; imem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
